// File: rtl/ins_cache_ctrl_pkg.sv
// Shared definitions for the instruction cache refill controller.
// The program counter imports the same state codes to gate its increments.
package ins_cache_ctrl_pkg;

  localparam int LOAD_TIMES_W = 10;
  localparam int ST_W         = 4;
  localparam int MISS_CNT_W   = 16;

  typedef enum logic [ST_W-1:0] {
    START    = 4'd1,
    LOAD_INS = 4'd2,
    SENT_INS = 4'd3
  } ins_cache_st_e;

endpackage

// File: rtl/ins_line_buffer.sv
// One block of instruction words: single write port, single registered read port.
// Written with plain indexed storage so it maps to distributed or block RAM.
module ins_line_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array is deliberately left without reset; resetting it
  // would turn every word into flops and block RAM inference would fail.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register may reset: it is the BRAM output latch, not the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ins_cache_ctrl.sv
// Instruction cache refill controller: loads one ISA_DEPTH-word block and serves
// the PC's fetch address. Define INS_CACHE_MISS_CNT_EN to build the refill counter.
module ins_cache_ctrl
  import ins_cache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH_MEM  = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int ISA_DEPTH       = 64,
  parameter int TOTAL_ISA_DEPTH = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
  output logic                      mem_rd_en,
  output logic [ADDR_WIDTH_MEM-1:0] mem_rd_addr,
  input  logic                      mem_rd_valid,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  output logic [DATA_WIDTH-1:0]     ins_out,
  output logic                      ins_out_valid,
  output logic                      ins_cache_rdy,
  output logic [ST_W-1:0]           st_cur_ins_cache,
  output logic [LOAD_TIMES_W-1:0]   load_times,
  output logic [MISS_CNT_W-1:0]     miss_cnt
);

  localparam int IDX_W = $clog2(ISA_DEPTH);
  localparam int BLK_W = ADDR_WIDTH_MEM - IDX_W;

  if (((ISA_DEPTH & (ISA_DEPTH - 1)) != 0) || ((TOTAL_ISA_DEPTH % ISA_DEPTH) != 0)) begin : g_bad_cfg
    $error("ins_cache_ctrl: ISA_DEPTH must be a power of two dividing TOTAL_ISA_DEPTH");
  end

  ins_cache_st_e            state;
  logic [BLK_W-1:0]         blk;
  logic [IDX_W-1:0]         k;
  logic                     pending;
  logic [LOAD_TIMES_W-1:0]  load_times_q;

  logic [BLK_W-1:0]         addr_blk;
  logic [IDX_W-1:0]         addr_idx;
  logic                     hit;
  logic                     word_cap;
  logic                     last_word;

  assign addr_blk = addr_ins[ADDR_WIDTH_MEM-1:IDX_W];
  assign addr_idx = addr_ins[IDX_W-1:0];

  // load_times holds block index plus one, so the resident block is load_times-1
  // (wrapping makes block 1023 resident when load_times reads 0).
  assign hit       = (LOAD_TIMES_W'(addr_blk) == (load_times_q - LOAD_TIMES_W'(1)));
  assign word_cap  = (state == LOAD_INS) && pending && mem_rd_valid;
  assign last_word = (k == IDX_W'(ISA_DEPTH - 1));

  assign ins_cache_rdy    = (state == SENT_INS) && hit;
  assign st_cur_ins_cache = state;
  assign load_times       = load_times_q;

  ins_line_buffer #(
    .DEPTH (ISA_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_line_buffer (
    .clk   (clk),
    .rst   (rst),
    .we    (word_cap),
    .waddr (k),
    .wdata (mem_rd_data),
    .re    (ins_cache_rdy),
    .raddr (addr_idx),
    .rdata (ins_out)
  );

  // NOTE: every register below uses non-blocking assignment so all state moves
  // together on the edge regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= START;
      blk           <= '0;
      k             <= '0;
      pending       <= 1'b0;
      load_times_q  <= '0;
      mem_rd_en     <= 1'b0;
      mem_rd_addr   <= '0;
      ins_out_valid <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      case (state)
        START: begin
          // First request issues here so it is on the bus in the first LOAD_INS cycle.
          blk           <= addr_blk;
          k             <= '0;
          pending       <= 1'b1;
          mem_rd_en     <= 1'b1;
          mem_rd_addr   <= {addr_blk, {IDX_W{1'b0}}};
          ins_out_valid <= 1'b0;
          state         <= LOAD_INS;
        end
        LOAD_INS: begin
          if (word_cap) begin
            pending <= 1'b0;
            if (last_word) begin
              k            <= '0;
              load_times_q <= LOAD_TIMES_W'(blk) + LOAD_TIMES_W'(1);
              state        <= SENT_INS;
            end else begin
              k           <= k + 1'b1;
              pending     <= 1'b1;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= {blk, k + 1'b1};
            end
          end
        end
        SENT_INS: begin
          ins_out_valid <= hit;
          if (!hit) begin
            state <= START;
          end
        end
        default: begin
          state <= START;
        end
      endcase
    end
  end

`ifdef INS_CACHE_MISS_CNT_EN
  logic [MISS_CNT_W-1:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt_q <= '0;
    end else if (word_cap && last_word && (miss_cnt_q != {MISS_CNT_W{1'b1}})) begin
      miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign miss_cnt = miss_cnt_q;
`else
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_ins_cache_ctrl.sv
// Self-checking bench for ins_cache_ctrl: variable-latency memory responder,
// a block-level reference model, and one task per scenario.
`timescale 1ns/1ps
module tb_ins_cache_ctrl;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int D   = 64;
  localparam int LTW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr_ins;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_valid;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] ins_out;
  logic          ins_out_valid;
  logic          ins_cache_rdy;
  logic [3:0]    st_cur_ins_cache;
  logic [LTW-1:0] load_times;
  logic [15:0]   miss_cnt;

  int checks   = 0;
  int failures = 0;

  // Memory responder state
  int            lat         = 2;
  int            cnt         = 0;
  int            resp_cnt    = 0;
  int            overlap_err = 0;
  logic [AW-1:0] pend_addr   = '0;
  logic [AW-1:0] rd_q [$];
  logic [15:0]   salt;

  // Reference model: which block should be resident, and refills completed
  int ref_blk  = -1;
  int exp_miss = 0;

  ins_cache_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .addr_ins         (addr_ins),
    .mem_rd_en        (mem_rd_en),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_valid     (mem_rd_valid),
    .mem_rd_data      (mem_rd_data),
    .ins_out          (ins_out),
    .ins_out_valid    (ins_out_valid),
    .ins_cache_rdy    (ins_cache_rdy),
    .st_cur_ins_cache (st_cur_ins_cache),
    .load_times       (load_times),
    .miss_cnt         (miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ salt, ~a};
  endfunction

  function automatic logic [15:0] exp_miss_cnt();
`ifdef INS_CACHE_MISS_CNT_EN
    return 16'(exp_miss);
`else
    return 16'd0;
`endif
  endfunction

  // Instruction memory: answers each request `lat` cycles after it is seen.
  initial begin
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      mem_rd_valid = 1'b0;
      mem_rd_data  = DW'($urandom);
      if (rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = mem_word(pend_addr);
            resp_cnt++;
          end
        end
        if (mem_rd_en === 1'b1) begin
          if (cnt != 0) overlap_err++;
          cnt       = lat;
          pend_addr = mem_rd_addr;
          rd_q.push_back(mem_rd_addr);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset(input string tag);
    checks++;
    if (st_cur_ins_cache !== 4'd1) begin
      failures++; $display("FAIL %s state: got %0d want 1", tag, st_cur_ins_cache);
    end
    checks++;
    if (load_times !== '0) begin
      failures++; $display("FAIL %s load_times: got %0d want 0", tag, load_times);
    end
    checks++;
    if (mem_rd_en !== 1'b0 || mem_rd_addr !== '0) begin
      failures++; $display("FAIL %s mem_rd: en=%b addr=%h want 0/0000", tag, mem_rd_en, mem_rd_addr);
    end
    checks++;
    if (ins_out !== '0 || ins_out_valid !== 1'b0) begin
      failures++; $display("FAIL %s ins_out: got %h valid=%b want 0 valid=0", tag, ins_out, ins_out_valid);
    end
    checks++;
    if (ins_cache_rdy !== 1'b0) begin
      failures++; $display("FAIL %s rdy: got %b want 0", tag, ins_cache_rdy);
    end
    checks++;
    if (miss_cnt !== 16'd0) begin
      failures++; $display("FAIL %s miss_cnt: got %0d want 0", tag, miss_cnt);
    end
  endtask

  // Waits for a refill of block blk to finish and checks what the model predicts.
  task automatic expect_refill(input string tag, input int blk);
    int  base_idx;
    int  n;
    int  bad_i;
    bit  ok;
    base_idx = rd_q.size();
    n = 0;
    while (st_cur_ins_cache === 4'd3 && n < 4) begin
      @(negedge clk); n++;
    end
    checks++;
    if (st_cur_ins_cache === 4'd3 || ins_cache_rdy !== 1'b0 || ins_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s miss_entry: state=%0d rdy=%b valid=%b want !=3/0/0",
               tag, st_cur_ins_cache, ins_cache_rdy, ins_out_valid);
    end
    n = 0;
    while (st_cur_ins_cache !== 4'd3 && n < 2000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (st_cur_ins_cache !== 4'd3) begin
      failures++; $display("FAIL %s refill_timeout: state=%0d want 3", tag, st_cur_ins_cache);
    end
    ref_blk = blk;
    exp_miss++;
    ok    = (rd_q.size() - base_idx) == D;
    bad_i = -1;
    for (int i = 0; i < D && ok; i++) begin
      if (rd_q[base_idx + i] !== AW'(blk * D + i)) begin
        ok = 1'b0; bad_i = i;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s reads: count=%0d first_bad=%0d want %0d reads from %h",
               tag, rd_q.size() - base_idx, bad_i, D, AW'(blk * D));
    end
    checks++;
    if (load_times !== LTW'(blk + 1)) begin
      failures++; $display("FAIL %s load_times: got %0d want %0d", tag, load_times, LTW'(blk + 1));
    end
    checks++;
    if (ins_cache_rdy !== 1'b1) begin
      failures++; $display("FAIL %s rdy_after: got %b want 1", tag, ins_cache_rdy);
    end
    checks++;
    if (miss_cnt !== exp_miss_cnt()) begin
      failures++; $display("FAIL %s miss_cnt: got %0d want %0d", tag, miss_cnt, exp_miss_cnt());
    end
    checks++;
    if (overlap_err != 0) begin
      failures++; $display("FAIL %s outstanding: got %0d overlapping reads want 0", tag, overlap_err);
    end
  endtask

  task automatic test_hits(input string tag, input int n, input bit seq);
    int            base_idx;
    logic [AW-1:0] a;
    base_idx = rd_q.size();
    for (int i = 0; i < n; i++) begin
      a = AW'(ref_blk * D + (seq ? (i % D) : int'($urandom_range(D - 1))));
      addr_ins = a;
      @(negedge clk);
      checks++;
      if (ins_out !== mem_word(a) || ins_out_valid !== 1'b1 || ins_cache_rdy !== 1'b1) begin
        failures++;
        $display("FAIL %s hit addr=%h: ins_out=%h valid=%b rdy=%b want %h/1/1",
                 tag, a, ins_out, ins_out_valid, ins_cache_rdy, mem_word(a));
      end
    end
    checks++;
    if (rd_q.size() != base_idx) begin
      failures++; $display("FAIL %s no_reads: got %0d reads want 0", tag, rd_q.size() - base_idx);
    end
  endtask

  task automatic test_boundary();
    addr_ins = AW'((ref_blk + 1) * D);
    #1;
    checks++;
    if (ins_cache_rdy !== 1'b0) begin
      failures++; $display("FAIL boundary rdy_drop: got %b want 0", ins_cache_rdy);
    end
    expect_refill("boundary", ref_blk + 1);
    test_hits("boundary_hits", 16, 1'b0);
  endtask

  task automatic test_interrupt();
    lat = int'($urandom_range(1, 3));
    addr_ins = 16'h8000;
    @(negedge clk);
    expect_refill("interrupt", 512);
    test_hits("interrupt_hits", 8, 1'b0);
  endtask

  task automatic test_return();
    lat = int'($urandom_range(1, 3));
    addr_ins = AW'(70);
    @(negedge clk);
    expect_refill("return", 1);
    @(negedge clk);
    checks++;
    if (ins_out !== mem_word(AW'(70)) || ins_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL return ins_out: got %h valid=%b want %h valid=1", ins_out, ins_out_valid, mem_word(AW'(70)));
    end
  endtask

  task automatic test_random_jumps(input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      lat = int'($urandom_range(1, 3));
      a = AW'($urandom_range(16'hFFFF));
      if (int'(a) / D == ref_blk) a = a ^ 16'h0400;
      addr_ins = a;
      @(negedge clk);
      expect_refill("jump", int'(a) / D);
      test_hits("jump_hits", 8, 1'b0);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [AW-1:0] a;
    int            base;
    int            n;
    lat = 2;
    a = AW'($urandom_range(16'hFFFF));
    if (int'(a) / D == ref_blk) a = a ^ 16'h0040;
    addr_ins = a;
    base = resp_cnt;
    n = 0;
    while ((resp_cnt - base) < 10 && n < 500) begin
      @(negedge clk); n++;
    end
    checks++;
    if ((resp_cnt - base) < 10) begin
      failures++; $display("FAIL mid_load words: got %0d want 10", resp_cnt - base);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset("mid_reset");
    exp_miss = 0;
    ref_blk  = -1;
    rst = 1'b0;
    expect_refill("cold_after_reset", int'(a) / D);
    test_hits("after_reset_hits", 8, 1'b0);
  endtask

  initial begin
    salt     = 16'($urandom);
    rst      = 1'b1;
    addr_ins = '0;
    lat      = 2;
    repeat (3) @(negedge clk);
    test_reset("reset");
    rst = 1'b0;
    expect_refill("cold", 0);
    test_hits("seq", D, 1'b1);
    test_boundary();
    test_interrupt();
    test_return();
    test_random_jumps(3);
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
